debug_mem_sequencer: RTL and testbench

DEBUG_MEM_SEQUENCER -- requirements
Module: debug_mem_sequencer

---
 rtl/debug_mem_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_debug_mem_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_mem_sequencer.sv
// debug_mem_sequencer
// Drives the CPU debug memory ports. It can stream program/data images into
// each channel, zero every channel, hold the core in reset and then let it run,
// and read every word back out as a stream of dump records.
module debug_mem_sequencer #(
  parameter int WORDS      = 4096,
  parameter int CHANNELS   = 2,
  parameter int RST_HOLD   = 5,
  parameter int RUN_CYCLES = 200000
) (
  input  logic                   CPU_CLK,
  input  logic                   CPU_RST,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [31:0]            src_data,
  input  logic                   src_last,
  output logic [CHANNELS*32-1:0] dbg_a2,
  output logic [31:0]            dbg_wd2,
  output logic [CHANNELS*4-1:0]  dbg_we2,
  input  logic [CHANNELS*32-1:0] dbg_rd2,
  output logic                   core_rst,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [7:0]             dump_chan,
  output logic [31:0]            dump_addr,
  output logic [31:0]            dump_data,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);
  localparam logic [31:0]   HOLD_LAST = 32'(RST_HOLD - 1);
  localparam logic [31:0]   RUN_LAST  = 32'(RUN_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, CLEAR, HOLD, RUN, DADDR, DWAIT, DOUT, DONE
  } stateType;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_DUMP  = 2'b01,
    MODE_CLEAR = 2'b10,
    MODE_FULL  = 2'b11
  } modeType;

  stateType      state;
  modeType       modeReg;
  logic [CW-1:0] chanIdx;
  logic [AW-1:0] wordIdx;
  logic [31:0]   cycleCnt;
  logic [31:0]   wordAddr;
  logic [31:0]   chanRd;
  logic          accept;
  logic          lastWord;
  logic          lastChan;

  // The load handshake is refused while reset is high so no word is consumed
  // or written in a reset cycle.
  assign src_ready = (state == LOAD) && !CPU_RST;
  assign accept    = src_valid && src_ready;
  assign lastWord  = (wordIdx == LAST_WORD);
  assign lastChan  = (chanIdx == LAST_CHAN);
  assign wordAddr  = {{(30-AW){1'b0}}, wordIdx, 2'b00};
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Select the read data of the channel currently being dumped.
  always_comb begin
    chanRd = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CW'(c) == chanIdx) chanRd = dbg_rd2[c*32 +: 32];
    end
  end

  // Memory port drive: only the active channel sees an address, and writes
  // happen in the same cycle a load word is accepted or on every clear cycle.
  always_comb begin
    dbg_a2  = '0;
    dbg_we2 = '0;
    dbg_wd2 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CW'(c) == chanIdx && (state == LOAD || state == CLEAR || state == DADDR)) begin
        dbg_a2[c*32 +: 32] = wordAddr;
        if (!CPU_RST && ((state == LOAD && accept) || state == CLEAR))
          dbg_we2[c*4 +: 4] = 4'b1111;
      end
    end
    if (state == LOAD && accept) dbg_wd2 = src_data;
  end

  // Sequencer FSM with its counters, core reset control and dump record registers.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state      <= IDLE;
      modeReg    <= MODE_LOAD;
      chanIdx    <= '0;
      wordIdx    <= '0;
      cycleCnt   <= '0;
      core_rst   <= 1'b1;
      dump_valid <= 1'b0;
      dump_chan  <= '0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            modeReg  <= modeType'(mode);
            chanIdx  <= '0;
            wordIdx  <= '0;
            cycleCnt <= '0;
            case (modeType'(mode))
              MODE_DUMP:  state <= DADDR;
              MODE_CLEAR: state <= CLEAR;
              default:    state <= LOAD;
            endcase
          end
        end

        LOAD: begin
          if (accept) begin
            if (src_last || lastWord) begin
              wordIdx <= '0;
              if (lastChan) begin
                chanIdx <= '0;
                if (modeReg == MODE_FULL) begin
                  state    <= HOLD;
                  core_rst <= 1'b1;
                  cycleCnt <= '0;
                end else begin
                  state <= DONE;
                end
              end else begin
                chanIdx <= chanIdx + 1'b1;
              end
            end else begin
              wordIdx <= wordIdx + 1'b1;
            end
          end
        end

        CLEAR: begin
          if (lastWord) begin
            wordIdx <= '0;
            if (lastChan) begin
              chanIdx <= '0;
              state   <= DONE;
            end else begin
              chanIdx <= chanIdx + 1'b1;
            end
          end else begin
            wordIdx <= wordIdx + 1'b1;
          end
        end

        HOLD: begin
          if (cycleCnt == HOLD_LAST) begin
            state    <= RUN;
            core_rst <= 1'b0;
            cycleCnt <= '0;
          end else begin
            cycleCnt <= cycleCnt + 32'd1;
          end
        end

        RUN: begin
          if (cycleCnt == RUN_LAST) begin
            state    <= DADDR;
            cycleCnt <= '0;
            chanIdx  <= '0;
            wordIdx  <= '0;
          end else begin
            cycleCnt <= cycleCnt + 32'd1;
          end
        end

        DADDR: state <= DWAIT;

        DWAIT: begin
          dump_data  <= chanRd;
          dump_chan  <= 8'(chanIdx);
          dump_addr  <= wordAddr;
          dump_valid <= 1'b1;
          state      <= DOUT;
        end

        DOUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (lastWord) begin
              wordIdx <= '0;
              if (lastChan) begin
                chanIdx <= '0;
                state   <= DONE;
              end else begin
                chanIdx <= chanIdx + 1'b1;
                state   <= DADDR;
              end
            end else begin
              wordIdx <= wordIdx + 1'b1;
              state   <= DADDR;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_sequencer.sv
// Testbench for debug_mem_sequencer: directed load, clear, full and dump
// scenarios with scoreboards for memory writes and dump records.
`timescale 1ns/1ps
module tb_debug_mem_sequencer;

  localparam int WORDS      = 8;
  localparam int CHANNELS   = 2;
  localparam int RST_HOLD   = 5;
  localparam int RUN_CYCLES = 20;
  localparam int AW         = 3;

  logic                   CPU_CLK = 1'b0;
  logic                   CPU_RST;
  logic                   start;
  logic [1:0]             mode;
  logic                   src_valid;
  logic                   src_ready;
  logic [31:0]            src_data;
  logic                   src_last;
  logic [CHANNELS*32-1:0] dbg_a2;
  logic [31:0]            dbg_wd2;
  logic [CHANNELS*4-1:0]  dbg_we2;
  logic [CHANNELS*32-1:0] dbg_rd2;
  logic                   core_rst;
  logic                   dump_valid;
  logic                   dump_ready;
  logic [7:0]             dump_chan;
  logic [31:0]            dump_addr;
  logic [31:0]            dump_data;
  logic                   busy;
  logic                   done;

  typedef struct {
    int          chan;
    logic [31:0] addr;
    logic [31:0] data;
  } recT;

  recT         writeQ[$];
  recT         dumpQ[$];
  recT         wExp;
  recT         dExp;
  logic [31:0] expMem [CHANNELS][WORDS];
  logic [31:0] mem [CHANNELS][WORDS];
  logic [31:0] rdReg [CHANNELS];
  int          total = 0;
  int          bad = 0;
  int          writesSeen = 0;
  int          dumpsSeen = 0;

  debug_mem_sequencer #(
    .WORDS(WORDS), .CHANNELS(CHANNELS), .RST_HOLD(RST_HOLD), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .start(start), .mode(mode),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_last(src_last),
    .dbg_a2(dbg_a2), .dbg_wd2(dbg_wd2), .dbg_we2(dbg_we2), .dbg_rd2(dbg_rd2),
    .core_rst(core_rst), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_chan(dump_chan), .dump_addr(dump_addr), .dump_data(dump_data),
    .busy(busy), .done(done)
  );

  // Free-running clock
  always #5 CPU_CLK = ~CPU_CLK;

  // Debug memory model: byte-enabled writes, reads with one cycle of latency
  always @(posedge CPU_CLK) begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (dbg_we2[c*4+b] === 1'b1)
          mem[c][dbg_a2[c*32+2 +: AW]][b*8 +: 8] <= dbg_wd2[b*8 +: 8];
      end
      rdReg[c] <= mem[c][dbg_a2[c*32+2 +: AW]];
    end
  end

  // Pack the per-channel read registers onto the read bus
  always_comb begin
    dbg_rd2 = '0;
    for (int c = 0; c < CHANNELS; c++) dbg_rd2[c*32 +: 32] = rdReg[c];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Write scoreboard: every write the DUT issues must match the oldest expected one
  always @(negedge CPU_CLK) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (dbg_we2[c*4 +: 4] !== 4'b0000) begin
        writesSeen++;
        if (writeQ.size() == 0) begin
          checkOutput("unexpected write", 32'(dbg_we2[c*4 +: 4]), 32'd0);
        end else begin
          wExp = writeQ.pop_front();
          checkOutput("write chan", 32'(c), 32'(wExp.chan));
          checkOutput("write addr", dbg_a2[c*32 +: 32], wExp.addr);
          checkOutput("write data", dbg_wd2, wExp.data);
          checkOutput("write enables", 32'(dbg_we2[c*4 +: 4]), 32'hF);
        end
      end
    end
  end

  // Dump scoreboard: each accepted record must match the oldest expected one
  always @(negedge CPU_CLK) begin
    if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
      dumpsSeen++;
      if (dumpQ.size() == 0) begin
        checkOutput("unexpected dump", 32'(dump_valid), 32'd0);
      end else begin
        dExp = dumpQ.pop_front();
        checkOutput("dump chan", 32'(dump_chan), 32'(dExp.chan));
        checkOutput("dump addr", dump_addr, dExp.addr);
        checkOutput("dump data", dump_data, dExp.data);
      end
    end
  end

  // Offer one load word, record the write it must cause, wait for acceptance.
  // Called at posedge+1 so acceptance lands in the same cycle.
  task automatic applyStimulus(input logic [31:0] data, input logic last,
                               input int chan, input int word);
    recT r;
    int  waitCnt;
    r.chan = chan;
    r.addr = 32'(word * 4);
    r.data = data;
    writeQ.push_back(r);
    expMem[chan][word] = data;
    src_valid = 1'b1;
    src_data  = data;
    src_last  = last;
    waitCnt   = 0;
    do begin
      @(negedge CPU_CLK);
      waitCnt++;
    end while (src_ready !== 1'b1 && waitCnt < 20);
    if (src_ready === 1'b1) begin
      @(posedge CPU_CLK);
      #1;
    end else begin
      checkOutput("src_ready timeout", 32'(src_ready), 32'd1);
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  // Pulse start for one cycle; mode is scrambled afterwards since it must be latched
  task automatic startOp(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    @(posedge CPU_CLK);
    #1;
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge CPU_CLK);
      n++;
    end while (done !== 1'b1 && n < limit);
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic pushDumpExpectations();
    recT r;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int w = 0; w < WORDS; w++) begin
        r.chan = c;
        r.addr = 32'(w * 4);
        r.data = expMem[c][w];
        dumpQ.push_back(r);
      end
    end
  endtask

  initial begin
    int highCnt;
    int lowCnt;
    int earlyValid;
    int w0;
    int d0;
    int n;
    recT r;

    CPU_RST    = 1'b1;
    start      = 1'b0;
    mode       = 2'b00;
    src_valid  = 1'b0;
    src_data   = '0;
    src_last   = 1'b0;
    dump_ready = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      for (int w = 0; w < WORDS; w++) expMem[c][w] = '0;

    $display("[TB] reset state");
    repeat (3) @(posedge CPU_CLK);
    @(negedge CPU_CLK);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset src_ready", 32'(src_ready), 32'd0);
    checkOutput("reset dump_valid", 32'(dump_valid), 32'd0);
    checkOutput("reset core_rst", 32'(core_rst), 32'd1);
    checkOutput("reset we", 32'(dbg_we2), 32'd0);
    checkOutput("reset a2 ch0", dbg_a2[31:0], 32'd0);
    checkOutput("reset a2 ch1", dbg_a2[63:32], 32'd0);
    checkOutput("reset wd2", dbg_wd2, 32'd0);
    @(posedge CPU_CLK);
    #1;
    CPU_RST = 1'b0;
    @(negedge CPU_CLK);
    checkOutput("idle core_rst held", 32'(core_rst), 32'd1);
    checkOutput("idle busy", 32'(busy), 32'd0);

    $display("[TB] load two short images");
    @(posedge CPU_CLK);
    #1;
    w0 = writesSeen;
    startOp(2'b00);
    applyStimulus(32'hA0A0_0001, 1'b0, 0, 0);
    start = 1'b1;
    mode  = 2'b10;
    applyStimulus(32'hB0B0_0002, 1'b0, 0, 1);
    start = 1'b0;
    applyStimulus(32'hC0C0_0003, 1'b1, 0, 2);
    repeat (3) begin
      @(negedge CPU_CLK);
      checkOutput("stall no write", 32'(dbg_we2), 32'd0);
      checkOutput("stall busy", 32'(busy), 32'd1);
    end
    @(posedge CPU_CLK);
    #1;
    applyStimulus(32'hD0D0_0004, 1'b0, 1, 0);
    applyStimulus(32'hE0E0_0005, 1'b1, 1, 1);
    @(negedge CPU_CLK);
    checkOutput("load done pulse", 32'(done), 32'd1);
    @(negedge CPU_CLK);
    checkOutput("done one cycle", 32'(done), 32'd0);
    checkOutput("idle after load", 32'(busy), 32'd0);
    checkOutput("load write count", 32'(writesSeen - w0), 32'd5);
    checkOutput("load writes drained", 32'(writeQ.size()), 32'd0);

    $display("[TB] overflow past channel size");
    @(posedge CPU_CLK);
    #1;
    w0 = writesSeen;
    startOp(2'b00);
    for (int i = 0; i < 10; i++)
      applyStimulus(32'h1900_0000 + 32'(i), 1'b0, (i < WORDS) ? 0 : 1, (i < WORDS) ? i : i - WORDS);
    applyStimulus(32'h19FF_FFFF, 1'b1, 1, 2);
    @(negedge CPU_CLK);
    checkOutput("overflow done pulse", 32'(done), 32'd1);
    checkOutput("overflow write count", 32'(writesSeen - w0), 32'd11);
    checkOutput("overflow writes drained", 32'(writeQ.size()), 32'd0);

    $display("[TB] reset during load");
    @(posedge CPU_CLK);
    #1;
    w0 = writesSeen;
    startOp(2'b00);
    applyStimulus(32'h2300_0000, 1'b0, 0, 0);
    applyStimulus(32'h2300_0001, 1'b0, 0, 1);
    src_valid = 1'b1;
    src_data  = 32'h2300_0002;
    CPU_RST   = 1'b1;
    @(negedge CPU_CLK);
    checkOutput("no write under reset", 32'(dbg_we2), 32'd0);
    checkOutput("no ready under reset", 32'(src_ready), 32'd0);
    @(posedge CPU_CLK);
    #1;
    CPU_RST = 1'b0;
    @(negedge CPU_CLK);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort we", 32'(dbg_we2), 32'd0);
    checkOutput("abort src_ready", 32'(src_ready), 32'd0);
    checkOutput("abort core_rst", 32'(core_rst), 32'd1);
    checkOutput("abort a2", dbg_a2[31:0], 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    src_valid = 1'b0;
    repeat (2) @(negedge CPU_CLK);
    checkOutput("abort write count", 32'(writesSeen - w0), 32'd2);

    $display("[TB] clear all channels");
    @(posedge CPU_CLK);
    #1;
    w0 = writesSeen;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int w = 0; w < WORDS; w++) begin
        r.chan = c;
        r.addr = 32'(w * 4);
        r.data = '0;
        writeQ.push_back(r);
        expMem[c][w] = '0;
      end
    end
    startOp(2'b10);
    for (int i = 0; i < WORDS * CHANNELS; i++) begin
      @(negedge CPU_CLK);
      checkOutput("clear write active", 32'(dbg_we2 != '0), 32'd1);
    end
    @(negedge CPU_CLK);
    checkOutput("clear done pulse", 32'(done), 32'd1);
    @(negedge CPU_CLK);
    checkOutput("clear done one cycle", 32'(done), 32'd0);
    checkOutput("clear idle", 32'(busy), 32'd0);
    checkOutput("clear write count", 32'(writesSeen - w0), 32'd16);

    $display("[TB] full load, hold, run, dump");
    @(posedge CPU_CLK);
    #1;
    d0 = dumpsSeen;
    startOp(2'b11);
    for (int w = 0; w < WORDS; w++)
      applyStimulus(32'h2100_0000 + 32'(w * 17), 1'b0, 0, w);
    for (int w = 0; w < 3; w++)
      applyStimulus(32'h21C1_0000 + 32'(w), (w == 2), 1, w);
    pushDumpExpectations();
    highCnt    = 0;
    lowCnt     = 0;
    earlyValid = 0;
    repeat (RST_HOLD) begin
      @(negedge CPU_CLK);
      if (core_rst === 1'b1) highCnt++;
    end
    repeat (RUN_CYCLES) begin
      @(negedge CPU_CLK);
      if (core_rst === 1'b0) lowCnt++;
      if (dump_valid !== 1'b0) earlyValid++;
    end
    checkOutput("hold cycles", 32'(highCnt), 32'(RST_HOLD));
    checkOutput("run cycles", 32'(lowCnt), 32'(RUN_CYCLES));
    checkOutput("no dump during run", 32'(earlyValid), 32'd0);
    @(negedge CPU_CLK);
    checkOutput("daddr no valid", 32'(dump_valid), 32'd0);
    @(negedge CPU_CLK);
    checkOutput("dwait no valid", 32'(dump_valid), 32'd0);
    @(negedge CPU_CLK);
    checkOutput("first record valid", 32'(dump_valid), 32'd1);
    repeat (10) begin
      @(negedge CPU_CLK);
      checkOutput("stalled valid", 32'(dump_valid), 32'd1);
      checkOutput("stalled chan", 32'(dump_chan), 32'd0);
      checkOutput("stalled addr", dump_addr, 32'd0);
      checkOutput("stalled data", dump_data, 32'h2100_0000);
    end
    @(posedge CPU_CLK);
    #1;
    dump_ready = 1'b1;
    waitDone("full done pulse", 200);
    checkOutput("full dump count", 32'(dumpsSeen - d0), 32'd16);
    checkOutput("full dumps drained", 32'(dumpQ.size()), 32'd0);
    checkOutput("core released after run", 32'(core_rst), 32'd0);

    $display("[TB] standalone dump with random backpressure");
    @(posedge CPU_CLK);
    #1;
    dump_ready = 1'b0;
    d0 = dumpsSeen;
    pushDumpExpectations();
    startOp(2'b01);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(posedge CPU_CLK);
      #1;
      dump_ready = 1'($urandom_range(0, 1));
      n++;
    end
    checkOutput("dump done pulse", 32'(done), 32'd1);
    @(negedge CPU_CLK);
    checkOutput("dump count", 32'(dumpsSeen - d0), 32'd16);
    checkOutput("dumps drained", 32'(dumpQ.size()), 32'd0);
    checkOutput("core stays released", 32'(core_rst), 32'd0);
    dump_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
